// File: rtl/fp_normalize_round.sv
// fp_normalize_round: sequential normalize, round-to-nearest-even and binary32 pack
// for the FP adder post-add stage, with valid/ready handshakes on both sides.
module fp_normalize_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] S,
    input  logic        Co,
    input  logic        SO,
    input  logic [7:0]  E,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t      state, state_n;
    logic [28:0] m, m_n;
    logic [9:0]  x, x_n, xr;
    logic        sign, sign_n, ovf_n, up;
    logic [31:0] result_n;
    logic [24:0] f;
    logic [23:0] fr;
    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            m      <= '0;
            x      <= '0;
            sign   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_n;
            m      <= m_n;
            x      <= x_n;
            sign   <= sign_n;
            result <= result_n;
            ovf    <= ovf_n;
        end
    end
    always_comb begin
        state_n  = state;
        m_n      = m;
        x_n      = x;
        sign_n   = sign;
        result_n = result;
        ovf_n    = ovf;
        up       = m[2] & (m[1] | m[0] | m[3]);
        f        = {1'b0, m[26:3]} + {24'd0, up};
        // a mantissa carry renormalizes by one place and bumps the exponent
        fr       = f[24] ? f[24:1] : f[23:0];
        xr       = x + {9'd0, f[24]};
        case (state)
            IDLE: if (in_valid) begin
                m_n     = {Co, S};
                sign_n  = SO;
                x_n     = (E == 8'd0) ? 10'd1 : {2'b00, E};
                state_n = NORM;
            end
            NORM: begin
                if (m == '0) state_n = ROUND;
                else if (m[28] | m[27]) begin
                    m_n = {1'b0, m[28:2], m[1] | m[0]};
                    x_n = x + 10'd1;
                end else if (!m[26] && x > 10'd1) begin
                    m_n = {m[27:0], 1'b0};
                    x_n = x - 10'd1;
                end else state_n = ROUND;
            end
            ROUND: begin
                // hidden bit still clear at X==1 leaves a denormal with a zero exponent field
                result_n = (m == '0)     ? {sign, 31'h0} :
                           (xr >= 10'd255) ? {sign, 8'hFF, 23'h0} :
                           {sign, fr[23] ? xr[7:0] : 8'h00, fr[22:0]};
                ovf_n    = (m != '0) && (xr >= 10'd255);
                state_n  = DONE;
            end
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: directed vectors pushed to a scoreboard queue; a monitor
// pops and compares result, ovf and latency whenever a result is accepted.
module tb_fp_normalize_round;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1, Co = 0, SO = 0;
    logic [27:0] S = '0;
    logic [7:0]  E = '0;
    logic        in_ready, out_valid, ovf;
    logic [31:0] result;
    int total = 0, bad = 0, cyc = 0, fv = 0;
    logic prev_ov = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
        int          start;
    } exp_t;
    exp_t q[$];

    fp_normalize_round dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .Co(Co), .SO(SO), .E(E), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_valid_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
            if (out_valid && !prev_ov) fv = cyc;
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output: got %h expected none", result);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                    chk("latency", fv - e.start, e.lat);
                end
            end
        end else prev_ov = 0;
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic send(input logic [27:0] s, input logic co, input logic so, input logic [7:0] e,
                        input logic [31:0] r, input logic o, input int lat);
        exp_t x;
        wait_ready();
        S = s; Co = co; SO = so; E = e; in_valid = 1;
        x.res = r; x.ovf = o; x.lat = lat; x.start = cyc;
        q.push_back(x);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: pending %0d expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        send(28'h4000000, 0, 0, 8'd127, 32'h3F800000, 0, 3);
        send(28'h8000000, 0, 0, 8'd127, 32'h40000000, 0, 4);
        send(28'h0000000, 1, 0, 8'd127, 32'h40800000, 0, 5);
        send(28'h0000008, 0, 0, 8'd127, 32'h34000000, 0, 26);
        send(28'h0000008, 0, 0, 8'd5,   32'h00000010, 0, 7);
        send(28'h4000004, 0, 0, 8'd127, 32'h3F800000, 0, 3);
        send(28'h400000C, 0, 0, 8'd127, 32'h3F800002, 0, 3);
        send(28'h7FFFFFC, 0, 0, 8'd127, 32'h40000000, 0, 3);
        send(28'h0000000, 1, 1, 8'd254, 32'hFF800000, 1, 5);
        send(28'h0000000, 0, 0, 8'd127, 32'h00000000, 0, 3);
        send(28'h4000000, 0, 0, 8'd0,   32'h00800000, 0, 3);
        send(28'h4000000, 0, 1, 8'd128, 32'hC0000000, 0, 3);
        drain();

        // downstream stall: result must hold while out_ready is low
        out_ready = 0;
        send(28'h400000C, 0, 1, 8'd127, 32'hBF800002, 0, 3);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", result, 32'hBF800002);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1;
        drain();

        // reset in the middle of a long left-shift run
        send(28'h0000008, 0, 0, 8'd127, 32'h34000000, 0, 26);
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1;
        q.delete();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_result", result, 32'h0);
        @(negedge clk);
        rst = 0;
        repeat (30) begin
            @(negedge clk);
            chk("post_rst_no_output", {31'd0, out_valid}, 32'd0);
        end
        send(28'h400000C, 0, 0, 8'd127, 32'h3F800002, 0, 3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
